// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST controller.
// Holds the FSM state encoding, vector count and the expected-gate function.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC  = 4;

    localparam int FUNC_AND = 0;
    localparam int FUNC_OR  = 1;
    localparam int FUNC_XOR = 2;

    function automatic logic gate_eval(input int func, input logic a, input logic b);
        case (func)
            FUNC_OR:  return a | b;
            FUNC_XOR: return a ^ b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/bist_dwell_timer.sv
// Dwell timer: counts edges while enabled and flags the last cycle of a dwell.
// Wraps to zero on its own at terminal count so consecutive vectors need no gap.
module bist_dwell_timer #(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

    logic [7:0] count;

    assign tc = enable && (count == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= tc ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/gate_bist.sv
// BIST controller for a single two-input gate: walks the four input vectors,
// holds each for DWELL cycles and checks the response on the last cycle.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   APPLY | driving vec onto dut_a/dut_b, comparing at end of each dwell
//   DONE  | results held (done=1) until the next start
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int DWELL = 20,
    parameter int FUNC  = 0,
    parameter int ERR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec
);

    state_t     state, state_nxt;
    logic [1:0] vec;
    logic       in_apply;
    logic       tc;
    logic       run_start;
    logic       cmp;
    logic       last_vec;
    logic       mismatch;

    assign in_apply = (state == APPLY);
    assign last_vec = (vec == 2'(NUM_VEC - 1));

    bist_dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (run_start),
        .enable (in_apply),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        cmp       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = APPLY;
                    run_start = 1'b1;
                end
            end
            APPLY: begin
                if (tc) begin
                    cmp = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mismatch = cmp && (dut_o != gate_eval(FUNC, vec[1], vec[0]));

    // Stimulus flops follow vec so the gate sees the vector for the whole dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec   <= 2'd0;
            dut_a <= 1'b0;
            dut_b <= 1'b0;
        end else if (run_start) begin
            vec   <= 2'd0;
            dut_a <= 1'b0;
            dut_b <= 1'b0;
        end else if (cmp) begin
            if (last_vec) begin
                vec   <= 2'd0;
                dut_a <= 1'b0;
                dut_b <= 1'b0;
            end else begin
                vec            <= vec + 2'd1;
                {dut_a, dut_b} <= vec + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            fail_vec  <= 2'd0;
        end else if (run_start) begin
            err_count <= '0;
            fail_vec  <= 2'd0;
        end else if (mismatch) begin
            if (err_count == '0) begin
                fail_vec <= vec;
            end
            if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign busy = in_apply;
    assign done = (state == DONE);
    // Combinational so the final compare of a run is already reflected when done rises.
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: AND/DWELL=20, XOR/DWELL=1 and OR/ERR_W=1 instances.
// Expected results are pushed when a run is started and popped when done rises.
module tb_gate_bist;

    typedef struct {
        int         lat;
        int         err;
        logic [1:0] fv;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;

    logic       start = 1'b0, dut_a, dut_b, dut_o, busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] fail_vec;

    logic       start_x = 1'b0, a_x, b_x, o_x, busy_x, done_x, pass_x;
    logic [2:0] err_x;
    logic [1:0] fv_x;

    logic       start_s = 1'b0, a_s, b_s, busy_s, done_s, pass_s;
    logic [0:0] err_s;
    logic [1:0] fv_s;

    always #5 clk = ~clk;

    assign dut_o = (mode == 0) ? (dut_a & dut_b) : (mode == 1) ? 1'b0 : 1'b1;
    assign o_x   = a_x ^ b_x;

    gate_bist #(.DWELL(20), .FUNC(0), .ERR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b),
        .dut_o(dut_o), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_bist #(.DWELL(1), .FUNC(2), .ERR_W(3)) dut_x (
        .clk(clk), .rst_n(rst_n), .start(start_x), .dut_a(a_x), .dut_b(b_x),
        .dut_o(o_x), .busy(busy_x), .done(done_x), .pass(pass_x),
        .err_count(err_x), .fail_vec(fv_x)
    );

    gate_bist #(.DWELL(2), .FUNC(1), .ERR_W(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .dut_a(a_s), .dut_b(b_s),
        .dut_o(1'b0), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .fail_vec(fv_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_main(input int m);
        exp_t e;
        e.err = 0;
        e.fv  = 2'd0;
        for (int v = 0; v < 4; v++) begin
            logic a, b, want, got;
            a    = v[1];
            b    = v[0];
            want = a & b;
            got  = (m == 0) ? want : (m == 1) ? 1'b0 : 1'b1;
            if (got != want) begin
                if (e.err == 0) e.fv = 2'(v);
                if (e.err < 7) e.err++;
            end
        end
        e.lat  = 80;
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({dut_a, dut_b, busy, done, pass, err_count, fail_vec} !== 10'd0) begin
            failures++;
            $display("FAIL reset_main got=%b want=0", {dut_a, dut_b, busy, done, pass, err_count, fail_vec});
        end
        checks++;
        if ({a_x, b_x, busy_x, done_x, pass_x, err_x, fv_x} !== 10'd0) begin
            failures++;
            $display("FAIL reset_xor got=%b want=0", {a_x, b_x, busy_x, done_x, pass_x, err_x, fv_x});
        end
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic wait_done_main(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            checks++;
            if (busy !== 1'b1 || {dut_a, dut_b} !== 2'(n / 20)) begin
                failures++;
                $display("FAIL apply_seq n=%0d got busy=%b ab=%b%b want busy=1 ab=%b", n, busy, dut_a, dut_b, 2'(n / 20));
            end
            step();
            n++;
        end
    endtask

    task automatic check_result_main(input string name, input int n);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, n, e.lat);
        end
        checks++;
        if (err_count !== 3'(e.err) || fail_vec !== e.fv || pass !== e.pass) begin
            failures++;
            $display("FAIL %s_result got err=%0d fv=%0d pass=%b want err=%0d fv=%0d pass=%b",
                     name, err_count, fail_vec, pass, e.err, e.fv, e.pass);
        end
        checks++;
        if (busy !== 1'b0 || {dut_a, dut_b} !== 2'b00) begin
            failures++;
            $display("FAIL %s_done_outputs got busy=%b ab=%b%b want 0 00", name, busy, dut_a, dut_b);
        end
    endtask

    task automatic run_main(input int m, input string name);
        int n;
        mode = m;
        sb.push_back(model_main(m));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done_main(n);
        check_result_main(name, n);
    endtask

    task automatic test_main_runs();
        run_main(0, "and_model");
        run_main(1, "stuck0");
        run_main(2, "stuck1");
        run_main(0, "and_model_again");
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 0;
        sb.push_back(model_main(0));
        sb.push_back(model_main(0));
        start = 1'b1;
        step();
        wait_done_main(n);
        check_result_main("hold_first", n);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_restart got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done_main(n);
        start = 1'b0;
        check_result_main("hold_second", n);
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL hold_stays_done got done=%b want 1", done);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done = 0;
        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        checks++;
        if (busy !== 1'b1 || {dut_a, dut_b} !== 2'b01) begin
            failures++;
            $display("FAIL abort_pre got busy=%b ab=%b%b want 1 01", busy, dut_a, dut_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_a, dut_b, busy, done, pass, err_count, fail_vec} !== 10'd0) begin
            failures++;
            $display("FAIL abort_async got=%b want=0", {dut_a, dut_b, busy, done, pass, err_count, fail_vec});
        end
        #2;
        rst_n = 1'b1;
        repeat (100) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_idle got active_cycles=%0d want=0", seen_done);
        end
        run_main(0, "after_abort");
    endtask

    task automatic test_xor_dwell1();
        exp_t e;
        int   n = 0;
        sb.push_back('{lat: 4, err: 0, fv: 2'd0, pass: 1'b1});
        start_x = 1'b1;
        step();
        start_x = 1'b0;
        while (done_x !== 1'b1 && n < 20) begin
            checks++;
            if (busy_x !== 1'b1 || {a_x, b_x} !== 2'(n)) begin
                failures++;
                $display("FAIL xor_seq n=%0d got busy=%b ab=%b%b want busy=1 ab=%b", n, busy_x, a_x, b_x, 2'(n));
            end
            step();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || pass_x !== e.pass || err_x !== 3'(e.err) || fv_x !== e.fv) begin
            failures++;
            $display("FAIL xor_result got lat=%0d pass=%b err=%0d fv=%0d want lat=%0d pass=%b err=%0d fv=%0d",
                     n, pass_x, err_x, fv_x, e.lat, e.pass, e.err, e.fv);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   n = 0;
        // OR expects 0,1,1,1 against a stuck-at-0 response: three misses, 1-bit counter.
        sb.push_back('{lat: 8, err: 1, fv: 2'd1, pass: 1'b0});
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        while (done_s !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (n !== e.lat || pass_s !== e.pass || err_s !== 1'(e.err) || fv_s !== e.fv) begin
            failures++;
            $display("FAIL sat_result got lat=%0d pass=%b err=%0d fv=%0d want lat=%0d pass=%b err=%0d fv=%0d",
                     n, pass_s, err_s, fv_s, e.lat, e.pass, e.err, e.fv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && busy === 1'b1 && done === 1'b1) begin
            failures++;
            $display("FAIL busy_done_overlap busy=%b done=%b want not both", busy, done);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_main_runs();
        test_back_to_back();
        test_reset_abort();
        test_xor_dwell1();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 The block SHALL have parameter DWELL, default 20, giving clock cycles each input vector is held; legal range 1..255.
REQ-002 The block SHALL have parameter FUNC, default 0, selecting the expected gate: 0=AND, 1=OR, 2=XOR.
REQ-003 The block SHALL have parameter ERR_W, default 3, giving the width of the error counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: level sampled each edge; launches a test run.
REQ-007 The block SHALL have ports dut_a and dut_b, each output, 1 bit: registered stimulus to the gate under test.
REQ-008 The block SHALL have port dut_o, input, 1 bit: response of the gate under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: high from run completion until the next run starts or reset.
REQ-011 The block SHALL have port pass, output, 1 bit: valid only when done is high; high iff err_count==0.
REQ-012 The block SHALL have port err_count, output, ERR_W bits: number of mismatching vectors in the last run.
REQ-013 The block SHALL have port fail_vec, output, 2 bits: index {a,b} of the first mismatching vector; 0 when there is none.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, APPLY and DONE.
REQ-015 In IDLE or DONE, when start=1 at an edge, the FSM SHALL enter APPLY with vec=0 and dwell count=0, and SHALL clear err_count, fail_vec and done.
REQ-016 In APPLY, dut_a SHALL equal vec[1] and dut_b SHALL equal vec[0]; vec SHALL step 0,1,2,3.
REQ-017 In APPLY, the dwell count SHALL increment each edge; at the edge where count==DWELL-1, the block SHALL compare dut_o with FUNC(vec[1],vec[0]).
REQ-018 On a mismatch, err_count SHALL increment, saturating at all-ones, and fail_vec SHALL be loaded only if err_count was 0.
REQ-019 At the compare edge, if vec<3 the FSM SHALL increment vec and clear the count; if vec==3 it SHALL enter DONE.
REQ-020 The done output SHALL rise exactly 4*DWELL edges after the edge that sampled start.
REQ-021 When DWELL==1, the block SHALL compare on every edge in APPLY, with no idle cycle between vectors.
REQ-022 The block SHALL ignore start while in APPLY; the run SHALL continue unchanged.
REQ-023 In IDLE and DONE, dut_a and dut_b SHALL be driven to 0.
REQ-024 busy SHALL equal (state==APPLY); busy and done SHALL never be high together.
REQ-025 When the last compare updates err_count and the FSM enters DONE on the same edge, pass SHALL reflect the updated count.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, vec=0, count=0, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0, immediately and independent of clk.
REQ-027 Reset asserted during APPLY SHALL abort the run with no done pulse; after release, the block SHALL wait in IDLE for start.

Structure
REQ-028 Package gate_bist_pkg SHALL hold the state enum, NUM_VEC=4, and the FUNC encodings with a function computing the expected output.
REQ-029 The dwell counter SHALL be the sub-module bist_dwell_timer, with inputs clear and enable, output terminal count, and parameter DWELL.
REQ-030 The top level SHALL contain the FSM, the vector register, the compare logic and the result registers.

Verification
REQ-031 Scenario: FUNC=0 with a correct AND model on dut_o, pulse start -> done at +80 edges, pass=1, err_count=0, fail_vec=0.
REQ-032 Scenario: FUNC=0 with dut_o stuck at 0 -> err_count=1, fail_vec=3, pass=0.
REQ-033 Scenario: FUNC=0 with dut_o stuck at 1 -> err_count=3, fail_vec=0, pass=0.
REQ-034 Scenario: start held high through the entire run -> exactly one run occurs; then the block restarts from DONE and done drops for 80 edges.
REQ-035 Scenario: rst_n pulsed low at edge 30 of a run -> all outputs 0 at once; no done; a later start gives a clean pass.
REQ-036 Scenario: DWELL=1, FUNC=2 with an XOR model -> dut_a/dut_b sequence 00,01,10,11 on consecutive edges; done at +4 edges; pass=1.
